mux_nway_sync: RTL and testbench

MUX_NWAY_SYNC -- requirements
Module: mux_nway_sync

---
 rtl/mux_nway_sync_pkg.sv | 18 +
 rtl/mux_nway_sync_blank_timer.sv | 30 +++
 rtl/mux_nway_sync.sv | 107 ++++++++++
 tb/tb_mux_nway_sync.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mux_nway_sync_pkg.sv
// Shared types and helpers for the N-way synchronous mux with blanking.
package mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BLANK = 1'b1
    } state_t;

    localparam int unsigned TIMER_W = 8;

    // Select width: clog2 of the channel count, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_nway_sync_blank_timer.sv
// Loadable down-counter that times the blanking interval.
module blank_timer
    import mux_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // High when the current decrement brings the count to zero.
    assign zero_c = (count <= W'(1));

endmodule

// File: rtl/mux_nway_sync.sv
// Registered N-way channel mux; a channel switch blanks the output for a fixed number of cycles.
module mux_nway_sync
    import mux_pkg::*;
#(
    parameter int unsigned          WIDTH        = 8,
    parameter int unsigned          NUM_CH       = 4,
    parameter int unsigned          BLANK_CYCLES = 2,
    parameter logic [WIDTH-1:0]     BLANK_VAL    = '0,
    localparam int unsigned         SEL_W        = sel_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel_req,
    input  logic                    sel_load,
    output logic [WIDTH-1:0]        out,
    output logic [SEL_W-1:0]        sel_cur,
    output logic                    busy,
    output logic                    sel_err
);

    localparam bit BYPASS = (BLANK_CYCLES == 0);

    state_t             state;
    logic [SEL_W-1:0]   pending;

    logic               req_ok_c;
    logic               req_bad_c;
    logic               switch_c;
    logic               tmr_load_c;
    logic               tmr_dec_c;
    logic               tmr_zero_c;
    logic [SEL_W-1:0]   src_c;
    logic [WIDTH-1:0]   ch_c;

    // Request qualification and channel source selection.
    always_comb begin
        req_ok_c   = sel_load && (32'(sel_req) < NUM_CH);
        req_bad_c  = sel_load && (32'(sel_req) >= NUM_CH);
        switch_c   = req_ok_c && (sel_req != sel_cur);
        tmr_load_c = !BYPASS && (((state == IDLE) && switch_c) ||
                                 ((state == BLANK) && req_ok_c));
        tmr_dec_c  = (state == BLANK);
        // At the end of blanking the out register already loads the new channel.
        src_c      = (state == BLANK) ? pending : sel_cur;
        ch_c       = in_bus[32'(src_c)*WIDTH +: WIDTH];
    end

    blank_timer #(
        .W        (TIMER_W)
    ) u_blank_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (TIMER_W'(BLANK_CYCLES)),
        .dec      (tmr_dec_c),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            out     <= BLANK_VAL;
            sel_cur <= '0;
            pending <= '0;
            busy    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= req_bad_c;
            case (state)
                IDLE: begin
                    out <= ch_c;
                    if (switch_c) begin
                        if (BYPASS) begin
                            sel_cur <= sel_req;
                        end else begin
                            pending <= sel_req;
                            state   <= BLANK;
                            busy    <= 1'b1;
                            out     <= BLANK_VAL;
                        end
                    end
                end
                BLANK: begin
                    if (req_ok_c) begin
                        // Last request wins and blanking restarts.
                        pending <= sel_req;
                        out     <= BLANK_VAL;
                    end else if (tmr_zero_c) begin
                        sel_cur <= pending;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        out     <= ch_c;
                    end else begin
                        out     <= BLANK_VAL;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    out   <= BLANK_VAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_nway_sync.sv
// Scoreboard bench: three mux builds share one randomized stimulus stream and a cycle-level reference model.
module tb_mux_nway_sync;

    localparam int ND = 3;

    typedef struct packed {
        logic [ND-1:0][7:0] out;
        logic [ND-1:0][1:0] sel;
        logic [ND-1:0]      busy;
        logic [ND-1:0]      err;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        in_bus = 32'h44332211;
    logic [1:0]         sel_req = 2'd0;
    logic               sel_load = 1'b0;
    logic [ND-1:0][7:0] dout;
    logic [ND-1:0][1:0] dsel;
    logic [ND-1:0]      dbusy;
    logic [ND-1:0]      derr;

    always #5 clk = ~clk;

    mux_nway_sync #(.WIDTH(8), .NUM_CH(4), .BLANK_CYCLES(2), .BLANK_VAL(8'h00)) u_a (
        .clk(clk), .rst(rst), .in_bus(in_bus), .sel_req(sel_req), .sel_load(sel_load),
        .out(dout[0]), .sel_cur(dsel[0]), .busy(dbusy[0]), .sel_err(derr[0]));

    mux_nway_sync #(.WIDTH(8), .NUM_CH(3), .BLANK_CYCLES(2), .BLANK_VAL(8'h00)) u_b (
        .clk(clk), .rst(rst), .in_bus(in_bus[23:0]), .sel_req(sel_req), .sel_load(sel_load),
        .out(dout[1]), .sel_cur(dsel[1]), .busy(dbusy[1]), .sel_err(derr[1]));

    mux_nway_sync #(.WIDTH(8), .NUM_CH(4), .BLANK_CYCLES(0), .BLANK_VAL(8'h5A)) u_c (
        .clk(clk), .rst(rst), .in_bus(in_bus), .sel_req(sel_req), .sel_load(sel_load),
        .out(dout[2]), .sel_cur(dsel[2]), .busy(dbusy[2]), .sel_err(derr[2]));

    // Reference model: per build, current channel, pending channel, blank cycles left.
    int         nch [ND] = '{4, 3, 4};
    int         blk [ND] = '{2, 2, 0};
    logic [7:0] bval[ND] = '{8'h00, 8'h00, 8'h5A};
    int         cur [ND];
    int         pend[ND];
    int         rem [ND];
    logic [7:0] mout[ND];
    logic       merr[ND];

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    function automatic logic [7:0] chan(input int k);
        logic [31:0] b;
        b = in_bus;
        return b[k*8 +: 8];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            cur[d]  = 0;
            pend[d] = 0;
            rem[d]  = 0;
            mout[d] = bval[d];
            merr[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int  req;
        bit  ok;
        req = int'(sel_req);
        for (int d = 0; d < ND; d++) begin
            ok      = sel_load && (req < nch[d]);
            merr[d] = sel_load && (req >= nch[d]);
            if (rem[d] > 0) begin
                if (ok) begin
                    pend[d] = req;
                    rem[d]  = blk[d];
                    mout[d] = bval[d];
                end else begin
                    rem[d] = rem[d] - 1;
                    if (rem[d] == 0) begin
                        cur[d]  = pend[d];
                        mout[d] = chan(cur[d]);
                    end else begin
                        mout[d] = bval[d];
                    end
                end
            end else begin
                mout[d] = chan(cur[d]);
                if (ok && req != cur[d]) begin
                    if (blk[d] == 0) begin
                        cur[d] = req;
                    end else begin
                        pend[d] = req;
                        rem[d]  = blk[d];
                        mout[d] = bval[d];
                    end
                end
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            e.out[d]  = mout[d];
            e.sel[d]  = 2'(cur[d]);
            e.busy[d] = (rem[d] > 0);
            e.err[d]  = merr[d];
        end
        expq.push_back(e);
    endtask

    task automatic chk(input string nm, input int d, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, d, act, exp_v, $time);
        end
    endtask

    // Monitor: compares registered outputs mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (expq.size() == 0) begin
                    chk("underflow", 0, 0, 1);
                end else begin
                    e = expq.pop_front();
                    for (int d = 0; d < ND; d++) begin
                        chk("out",     d, int'(dout[d]),  int'(e.out[d]));
                        chk("sel_cur", d, int'(dsel[d]),  int'(e.sel[d]));
                        chk("busy",    d, int'(dbusy[d]), int'(e.busy[d]));
                        chk("sel_err", d, int'(derr[d]),  int'(e.err[d]));
                    end
                end
            end
        end
    end

    // One clock: model the edge, apply next inputs, optionally assert reset between edges.
    task automatic cycle(input logic ld, input logic [1:0] rq, input logic [31:0] bus, input bit arst);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        rst      = 1'b0;
        sel_load = ld;
        sel_req  = rq;
        in_bus   = bus;
        if (arst) begin
            #1;
            rst = 1'b1;
            model_reset();
        end
        push_expected();
        mon_on = 1'b1;
    endtask

    initial begin
        logic [31:0] b;
        b = 32'h44332211;
        repeat (3) cycle(1'b0, 2'd0, b, 1'b0);
        cycle(1'b1, 2'd2, b, 1'b0);
        repeat (5) cycle(1'b0, 2'd0, b, 1'b0);
        cycle(1'b1, 2'd1, b, 1'b0);
        cycle(1'b1, 2'd3, b, 1'b0);
        repeat (6) cycle(1'b0, 2'd0, b, 1'b0);
        cycle(1'b1, 2'd3, b, 1'b0);
        repeat (3) cycle(1'b0, 2'd0, b, 1'b0);
        cycle(1'b1, 2'd1, b, 1'b0);
        cycle(1'b0, 2'd0, b, 1'b0);
        cycle(1'b0, 2'd0, b, 1'b1);
        repeat (4) cycle(1'b0, 2'd0, b, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 99) == 0));
        end
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        chk("drain", 0, expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
